// File: rtl/circuito_sweep.sv
// Exhaustive 512-vector sweep of circuito inputs; counts X ones, optional MISR (CIRCUITO_SWEEP_MISR_EN).
// Latency: 512*SETTLE+1 edges from START to DONE; no backpressure, START only sampled in IDLE.
// Outputs are registered; SIG is tied to zero unless CIRCUITO_SWEEP_MISR_EN is defined.
module circuito_sweep #(
  parameter int SETTLE = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        X,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        E,
  output logic        F,
  output logic        G,
  output logic        H,
  output logic        I,
  output logic        BUSY,
  output logic        DONE,
  output logic [9:0]  ONES,
  output logic [15:0] SIG
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [8:0] idx;
  logic [8:0] vec;
  logic [3:0] cnt;
  logic       sample;
  logic       accept;

  assign sample = (state == RUN) && (cnt == CNT_LAST);
  assign accept = (state == IDLE) && START;
  assign {A, B, C, D, E, F, G, H, I} = vec;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      idx   <= '0;
      vec   <= '0;
      cnt   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      ONES  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            idx   <= '0;
            vec   <= '0;
            cnt   <= '0;
            ONES  <= '0;
            BUSY  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (cnt == CNT_LAST) begin
            cnt  <= '0;
            ONES <= ONES + {9'd0, X};
            // Index 511 leaves through FIN; it never wraps inside RUN.
            if (idx == 9'd511) begin
              state <= FIN;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              vec   <= '0;
            end else begin
              idx <= idx + 9'd1;
              vec <= idx + 9'd1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        FIN: begin
          DONE  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CIRCUITO_SWEEP_MISR_EN
  logic [15:0] sig_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sig_q <= '0;
    end else if (accept) begin
      sig_q <= 16'hFFFF;
    end else if (sample) begin
      sig_q <= {sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10] ^ X};
    end
  end

  assign SIG = sig_q;
`else
  logic unused_misr;
  assign unused_misr = accept ^ sample;
  assign SIG = 16'h0000;
`endif

endmodule

// File: tb/tb_circuito_sweep.sv
// Scoreboard bench for circuito_sweep: directed sweeps with X modelled from the stimulus bits.
module tb_circuito_sweep;

  typedef struct packed {
    logic [9:0]  ones;
    logic [15:0] sig;
  } exp_t;

  logic clk, rst_n;
  logic start, start1;
  int   xmode;
  int   checks, failures, done_cnt;
  exp_t q0[$];
  exp_t q1[$];

  logic a, b, c, d, e, f, g, h, i, busy, done, x0;
  logic [9:0]  ones;
  logic [15:0] sig;
  logic [8:0]  vec0;

  logic a1, b1, c1, d1, e1, f1, g1, h1, i1, busy1, done1, x1;
  logic [9:0]  ones1;
  logic [15:0] sig1;
  logic [8:0]  vec1;

  assign vec0 = {a, b, c, d, e, f, g, h, i};
  assign vec1 = {a1, b1, c1, d1, e1, f1, g1, h1, i1};
  assign x0   = (xmode == 0) ? a : (xmode == 1);
  assign x1   = ^vec1;

  circuito_sweep #(.SETTLE(2)) u_dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .X(x0),
    .A(a), .B(b), .C(c), .D(d), .E(e), .F(f), .G(g), .H(h), .I(i),
    .BUSY(busy), .DONE(done), .ONES(ones), .SIG(sig)
  );

  circuito_sweep #(.SETTLE(1)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start1), .X(x1),
    .A(a1), .B(b1), .C(c1), .D(d1), .E(e1), .F(f1), .G(g1), .H(h1), .I(i1),
    .BUSY(busy1), .DONE(done1), .ONES(ones1), .SIG(sig1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference signature for a full sweep; mode 0: X=A, 1: X=1, 2: X=0, 3: odd parity.
  function automatic logic [15:0] misr_ref(input int mode);
    logic [15:0] s;
    logic [8:0]  v;
    logic        xb;
    s = 16'hFFFF;
    for (int k = 0; k < 512; k++) begin
      v  = 9'(k);
      xb = (mode == 0) ? v[8] : (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ^v;
      s  = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ xb};
    end
`ifdef CIRCUITO_SWEEP_MISR_EN
    return s;
`else
    return 16'h0000;
`endif
  endfunction

  function automatic exp_t mk(input int n, input int mode);
    exp_t r;
    r.ones = 10'(n);
    r.sig  = misr_ref(mode);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", done, 1);
  endtask

  task automatic wait_vec(input logic [8:0] v);
    int n = 0;
    while (vec0 != v && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("wait_vec", vec0, v);
  endtask

  task automatic sweep(input int mode, input int n_ones);
    xmode = mode;
    q0.push_back(mk(n_ones, mode));
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done();
    tick(2);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t ex;
      done_cnt++;
      if (q0.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        ex = q0.pop_front();
        check("ones", ones, ex.ones);
        check("sig", sig, ex.sig);
      end
    end
    if (rst_n && done1) begin
      exp_t ex1;
      if (q1.size() == 0) begin
        check("unexpected_done1", 1, 0);
      end else begin
        ex1 = q1.pop_front();
        check("ones1", ones1, ex1.ones);
        check("sig1", sig1, ex1.sig);
      end
    end
  end

  initial begin
    int nb, lo, bad_at, dc;
    checks = 0; failures = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; xmode = 0;
    tick(3);
    check("rst_vec", vec0, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ones", ones, 0);
    check("rst_sig", sig, 0);
    rst_n = 1'b1;
    tick(2);

    // X = A, SETTLE = 2: each vector held two cycles, BUSY for 1024 cycles.
    xmode = 0;
    q0.push_back(mk(256, 0));
    start = 1'b1;
    tick(1);
    start = 1'b0;
    nb = 0; bad_at = -1;
    for (int k = 0; k < 1024; k++) begin
      if (busy) nb++;
      if (vec0 != 9'(k / 2) && bad_at < 0) bad_at = k;
      tick(1);
    end
    check("busy_len", nb, 1024);
    check("step_first_bad", bad_at, -1);
    check("fin_done", done, 1);
    check("fin_busy", busy, 0);
    check("fin_vec", vec0, 0);
    tick(1);
    check("idle_done", done, 0);
    tick(3);
    check("ones_hold", ones, 256);

    sweep(1, 512);
    sweep(2, 0);
    sweep(1, 512);

    // START again at vector 100 is ignored.
    xmode = 0;
    q0.push_back(mk(256, 0));
    start = 1'b1;
    tick(1);
    start = 1'b0;
    dc = done_cnt;
    wait_vec(9'd100);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    check("no_restart", int'(vec0 >= 9'd100), 1);
    wait_done();
    tick(1100);
    check("single_done", done_cnt - dc, 1);

    // Reset at vector 300 aborts asynchronously.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_vec(9'd300);
    #2 rst_n = 1'b0;
    #1;
    check("abort_vec", vec0, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ones", ones, 0);
    check("abort_sig", sig, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dc = done_cnt; nb = 0;
    repeat (1100) begin
      @(negedge clk);
      if (busy) nb++;
    end
    check("idle_after_rst", nb, 0);
    check("no_done_after_rst", done_cnt - dc, 0);

    // START held high: three back-to-back sweeps.
    xmode = 0;
    for (int s = 0; s < 3; s++) q0.push_back(mk(256, 0));
    start = 1'b1;
    for (int s = 0; s < 3; s++) begin
      lo = 0;
      while (!busy && lo < 10) begin
        tick(1);
        lo++;
      end
      check("b2b_busy_rise", busy, 1);
      check("b2b_ones_clr", ones, 0);
      if (s == 2) start = 1'b0;
      nb = 0;
      while (busy && nb < 1100) begin
        tick(1);
        nb++;
      end
      check("b2b_busy_len", nb, 1024);
      if (s < 2) begin
        lo = 0;
        while (!busy && lo < 10) begin
          lo++;
          tick(1);
        end
        check("b2b_busy_low", lo, 2);
      end
    end
    tick(5);
    check("b2b_stop", busy, 0);

    // Odd parity, SETTLE = 1: one vector per cycle.
    q1.push_back(mk(256, 3));
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    nb = 0; bad_at = -1;
    while (busy1 && nb < 600) begin
      if (vec1 != 9'(nb) && bad_at < 0) bad_at = nb;
      nb++;
      tick(1);
    end
    check("s1_busy_len", nb, 512);
    check("s1_step_first_bad", bad_at, -1);
    check("s1_done", done1, 1);
    tick(5);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/circuito_sweep.md
# circuito_sweep

Exhaustive stimulus sequencer that sits directly upstream of the `circuito` combinational block. It drives the nine inputs A–I through all 512 combinations and samples output X after a programmable settle time. It returns a count of ones over the sweep and, optionally, a 16-bit MISR signature, so the truth table can be checked in hardware against a golden value.

## Interface
Parameters:
- `SETTLE`, default 2: cycles each vector is held before X is sampled. Legal range 1..15.

Ports:
- `CLK`  in  1  rising-edge clock.
- `RST_N`  in  1  asynchronous, active-low reset.
- `START`  in  1  level request to begin a sweep; sampled only in IDLE.
- `X`  in  1  output of `circuito` under test.
- `A`,`B`,`C`,`D`,`E`,`F`,`G`,`H`,`I`  out  1 each  stimulus bits; A = IDX[8] (MSB) … I = IDX[0] (LSB).
- `BUSY`  out  1  high while a sweep is in progress.
- `DONE`  out  1  one-cycle pulse at sweep completion.
- `ONES`  out  10  number of vectors for which sampled X = 1 (0..512).
- `SIG`  out  16  MISR signature of the X sequence.

## Operation
- Internal state: FSM {IDLE, RUN, FIN}, 9-bit vector index IDX, 4-bit settle counter CNT.
- IDLE: A–I = 0, BUSY = 0. On a clock edge with START = 1, the block loads:
  - IDX = 0, CNT = 0
  - ONES = 0, SIG = 16'hFFFF
  - state = RUN
- RUN: A–I = IDX, BUSY = 1.
  - CNT increments each cycle.
  - On the edge where CNT = SETTLE−1, the block samples X, then:
    - ONES += X
    - SIG updates (see Configuration)
    - CNT = 0
    - if IDX = 511, state = FIN; otherwise IDX += 1.
- FIN: one cycle with DONE = 1, BUSY = 0, A–I = 0. The next state is IDLE.
- ONES and SIG hold their values from FIN until the next accepted START.
- START in RUN or FIN is ignored.
- If START is still high in the IDLE cycle after FIN, a new sweep starts (START is level-sensitive).
- ONES cannot overflow: its maximum is 512, which fits in 10 bits.
- IDX wraps only through FIN. There is no 511→0 wrap inside RUN.

## Timing
- Reset (RST_N = 0, asynchronous): state = IDLE, IDX = 0, CNT = 0, A–I = 0, BUSY = 0, DONE = 0, ONES = 0, SIG = 0. The block stays idle until RST_N rises and then START is seen.
- Reset asserted mid-sweep aborts immediately. No DONE pulse is produced and partial results are cleared.
- START high at edge t: BUSY = 1 and A–I = 0 from t+1.
- Each vector is applied for exactly SETTLE cycles. X is captured at the end of the last cycle, so `circuito` gets SETTLE−1 full cycles plus one partial cycle to settle.
- The last sample occurs at edge t + 512·SETTLE. DONE is high during the following cycle, and BUSY falls at that same edge.
- Total start-to-DONE latency: 512·SETTLE + 1 edges.
- X is treated as synchronous to CLK. No synchronizer is included.

## Configuration
- `CIRCUITO_SWEEP_MISR_EN` defined: SIG is a 16-bit Fibonacci MISR, seeded with 16'hFFFF on START. On each sample:
  - SIG ← {SIG[14:0], SIG[15]^SIG[13]^SIG[12]^SIG[10]^X}
- Macro not defined:
  - no MISR logic is built and SIG is tied to 16'h0000 at all times;
  - ONES and all timing are unchanged.

## Test plan
- Bench models X = A, SETTLE = 2, START pulsed one cycle. Required:
  - BUSY high for 1024 cycles;
  - A–I step 0,0,1,1,2,2,… (each value held 2 cycles) through 511;
  - DONE one-cycle pulse, then ONES = 256.
- X tied 1, then tied 0. Required: ONES = 512 and ONES = 0 respectively. With the MISR enabled, each SIG matches the bench reference model, and a repeated sweep gives an identical SIG.
- X = A^B^…^I (odd parity), SETTLE = 1. Required: ONES = 256, sweep completes in 512 cycles after BUSY rises, and each vector is held exactly one cycle.
- START pulsed again at vector 100 mid-sweep. Required: ignored, IDX continues without restarting, and a single DONE is produced.
- RST_N pulled low at vector 300. Required:
  - A–I, BUSY, DONE, ONES, SIG all 0 immediately (asynchronously);
  - no DONE pulse;
  - after release with START low, the block stays in IDLE.
- START held high continuously. Required: back-to-back sweeps, one DONE per sweep, BUSY low only during the FIN cycle and the IDLE cycle, and ONES reset to 0 at the start of each sweep.
